// File: rtl/regfile_2r1w_sb.sv
// Two-read/one-write register file with source-selected writes, optional
// write-to-read bypass and a single-outstanding-load scoreboard.
module regfile_2r1w_sb #(
  parameter int A        = 4,
  parameter int W        = 8,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         Reset_n,
  input  logic         Write_En,
  input  logic [1:0]   Src_Sel,
  input  logic [A-1:0] Wr_Addr,
  input  logic [W-1:0] ALU_Input,
  input  logic [W-1:0] Acc_Input,
  input  logic [W-1:0] Mem_Input,
  input  logic         Load_Issue,
  input  logic [A-1:0] Load_Addr,
  input  logic         Load_Done,
  input  logic [A-1:0] Rd_AddrA,
  input  logic [A-1:0] Rd_AddrB,
  output logic [W-1:0] DataA,
  output logic [W-1:0] DataB,
  output logic         Stall_A,
  output logic         Stall_B,
  output logic         Busy
);

  localparam int N = 2**A;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   pend_addr_q, pend_addr_d;
  logic [W-1:0]   regs_q [N];

  logic [W-1:0]   wr_data;
  logic           wr_en;
  logic           ld_done_pend;
  logic           waw_hit;
  logic           ld_wr;

  always_comb begin
    wr_data = Mem_Input;
    case (Src_Sel)
      2'b01:   wr_data = Acc_Input;
      2'b10:   wr_data = ALU_Input;
      default: wr_data = Mem_Input;
    endcase
  end

  assign wr_en        = Write_En && (Src_Sel != 2'b11) &&
                        !((ZERO_REG != 0) && (Wr_Addr == '0));
  assign ld_done_pend = (state_q == PENDING) && Load_Done;
  // A normal write to the pending destination supersedes the load (WAW).
  assign waw_hit      = (state_q == PENDING) && wr_en && (Wr_Addr == pend_addr_q);
  assign ld_wr        = ld_done_pend && !waw_hit;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    case (state_q)
      IDLE: begin
        if (Load_Issue && !((ZERO_REG != 0) && (Load_Addr == '0))) begin
          state_d     = PENDING;
          pend_addr_d = Load_Addr;
        end
      end
      PENDING: begin
        if (Load_Done || waw_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en && (Wr_Addr == A'(i)))
          regs_q[i] <= wr_data;
        else if (ld_wr && (pend_addr_q == A'(i)))
          regs_q[i] <= Mem_Input;
      end
    end
  end

  function automatic logic [W-1:0] read_port(input logic [A-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    else if ((BYPASS != 0) && wr_en && (Wr_Addr == addr))
      return wr_data;
    else if ((BYPASS != 0) && ld_done_pend && (pend_addr_q == addr))
      return Mem_Input;
    else
      return regs_q[addr];
  endfunction

  function automatic logic stall_port(input logic [A-1:0] addr);
    return (state_q == PENDING) && (addr == pend_addr_q) &&
           !((BYPASS != 0) && Load_Done) &&
           !((ZERO_REG != 0) && (addr == '0));
  endfunction

  always_comb begin
    DataA   = read_port(Rd_AddrA);
    DataB   = read_port(Rd_AddrB);
    Stall_A = stall_port(Rd_AddrA);
    Stall_B = stall_port(Rd_AddrB);
  end

  assign Busy = (state_q == PENDING);

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: three configurations driven in parallel
// (bypass, no bypass, zero register) against an array-based reference model.
module tb_regfile_2r1w_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset_n;
  logic       Write_En;
  logic [1:0] Src_Sel;
  logic [3:0] Wr_Addr;
  logic [7:0] ALU_Input, Acc_Input, Mem_Input;
  logic       Load_Issue;
  logic [3:0] Load_Addr;
  logic       Load_Done;
  logic [3:0] Rd_AddrA, Rd_AddrB;

  logic [7:0] dA [3];
  logic [7:0] dB [3];
  logic       sA [3];
  logic       sB [3];
  logic       bz [3];

  int checks = 0;
  int errors = 0;

  // Config k: 0 = bypass, 1 = no bypass, 2 = zero register + bypass
  bit zr_c [3] = '{1'b0, 1'b0, 1'b1};
  bit bp_c [3] = '{1'b1, 1'b0, 1'b1};

  regfile_2r1w_sb #(.A(4), .W(8), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk(clk), .Reset_n(Reset_n), .Write_En(Write_En), .Src_Sel(Src_Sel),
    .Wr_Addr(Wr_Addr), .ALU_Input(ALU_Input), .Acc_Input(Acc_Input),
    .Mem_Input(Mem_Input), .Load_Issue(Load_Issue), .Load_Addr(Load_Addr),
    .Load_Done(Load_Done), .Rd_AddrA(Rd_AddrA), .Rd_AddrB(Rd_AddrB),
    .DataA(dA[0]), .DataB(dB[0]), .Stall_A(sA[0]), .Stall_B(sB[0]), .Busy(bz[0]));

  regfile_2r1w_sb #(.A(4), .W(8), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .Reset_n(Reset_n), .Write_En(Write_En), .Src_Sel(Src_Sel),
    .Wr_Addr(Wr_Addr), .ALU_Input(ALU_Input), .Acc_Input(Acc_Input),
    .Mem_Input(Mem_Input), .Load_Issue(Load_Issue), .Load_Addr(Load_Addr),
    .Load_Done(Load_Done), .Rd_AddrA(Rd_AddrA), .Rd_AddrB(Rd_AddrB),
    .DataA(dA[1]), .DataB(dB[1]), .Stall_A(sA[1]), .Stall_B(sB[1]), .Busy(bz[1]));

  regfile_2r1w_sb #(.A(4), .W(8), .ZERO_REG(1), .BYPASS(1)) u2 (
    .clk(clk), .Reset_n(Reset_n), .Write_En(Write_En), .Src_Sel(Src_Sel),
    .Wr_Addr(Wr_Addr), .ALU_Input(ALU_Input), .Acc_Input(Acc_Input),
    .Mem_Input(Mem_Input), .Load_Issue(Load_Issue), .Load_Addr(Load_Addr),
    .Load_Done(Load_Done), .Rd_AddrA(Rd_AddrA), .Rd_AddrB(Rd_AddrB),
    .DataA(dA[2]), .DataB(dB[2]), .Stall_A(sA[2]), .Stall_B(sB[2]), .Busy(bz[2]));

  // Reference model state
  logic [7:0] mdl [3][16];
  logic       mpend [3];
  logic [3:0] mpa [3];

  function automatic logic [7:0] m_src();
    case (Src_Sel)
      2'b00:   return Mem_Input;
      2'b01:   return Acc_Input;
      default: return ALU_Input;
    endcase
  endfunction

  function automatic bit m_nw(input int k);
    return Write_En && (Src_Sel != 2'b11) && !(zr_c[k] && Wr_Addr == 4'd0);
  endfunction

  function automatic logic [7:0] m_read(input int k, input logic [3:0] a);
    if (zr_c[k] && a == 4'd0) return 8'h00;
    if (bp_c[k] && m_nw(k) && Wr_Addr == a) return m_src();
    if (bp_c[k] && mpend[k] && Load_Done && mpa[k] == a) return Mem_Input;
    return mdl[k][a];
  endfunction

  function automatic logic m_stall(input int k, input logic [3:0] a);
    if (zr_c[k] && a == 4'd0) return 1'b0;
    return mpend[k] && (a == mpa[k]) && !(bp_c[k] && Load_Done);
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 16; r++) mdl[k][r] = 8'h00;
      mpend[k] = 1'b0;
      mpa[k]   = 4'd0;
    end
  endtask

  // Advance one clock edge and apply the architectural effect to the model.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (mpend[k]) begin
        if (m_nw(k) && Wr_Addr == mpa[k]) begin
          mdl[k][Wr_Addr] = m_src();
          mpend[k] = 1'b0;
        end else begin
          if (m_nw(k)) mdl[k][Wr_Addr] = m_src();
          if (Load_Done) begin
            mdl[k][mpa[k]] = Mem_Input;
            mpend[k] = 1'b0;
          end
        end
      end else begin
        if (m_nw(k)) mdl[k][Wr_Addr] = m_src();
        if (Load_Issue && !(zr_c[k] && Load_Addr == 4'd0)) begin
          mpend[k] = 1'b1;
          mpa[k]   = Load_Addr;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    Write_En = 1'b0; Load_Issue = 1'b0; Load_Done = 1'b0;
  endtask

  task automatic test_reset();
    #1 Reset_n = 1'b0;
    m_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h00 || sA[k] !== 1'b0 || bz[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_init k=%0d got data=%h stall=%b busy=%b exp 00/0/0", k, dA[k], sA[k], bz[k]);
      end
    end
    @(negedge clk) Reset_n = 1'b1;
    @(negedge clk);
    Write_En = 1'b1; Src_Sel = 2'b10; Wr_Addr = 4'd3; ALU_Input = 8'hA5;
    step();
    @(negedge clk);
    idle_inputs(); Rd_AddrA = 4'd3; Load_Issue = 1'b1; Load_Addr = 4'd5;
    step();
    @(negedge clk);
    Load_Issue = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'hA5 || bz[k] !== 1'b1) begin
        errors++;
        $display("FAIL pre_reset k=%0d got data=%h busy=%b exp a5/1", k, dA[k], bz[k]);
      end
    end
    #1 Reset_n = 1'b0;
    m_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h00 || bz[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset k=%0d got data=%h busy=%b exp 00/0", k, dA[k], bz[k]);
      end
    end
    #1 Reset_n = 1'b1;
    step();
    @(negedge clk);
    Load_Done = 1'b1; Mem_Input = 8'h5A; Rd_AddrA = 4'd5;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h00 || bz[k] !== 1'b0) begin
        errors++;
        $display("FAIL stale_done k=%0d got data=%h busy=%b exp 00/0", k, dA[k], bz[k]);
      end
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h00) begin
        errors++;
        $display("FAIL dropped_load k=%0d got=%h exp=00", k, dA[k]);
      end
    end
  endtask

  task automatic test_src_mux();
    logic [1:0] sel [4]  = '{2'b10, 2'b01, 2'b00, 2'b11};
    logic [3:0] addr [4] = '{4'd1, 4'd2, 4'd4, 4'd5};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Write_En = 1'b1; Src_Sel = sel[i]; Wr_Addr = addr[i];
      ALU_Input = 8'h11; Acc_Input = 8'h22; Mem_Input = 8'h33;
      if (i == 0) ALU_Input = 8'h11;
      step();
    end
    @(negedge clk);
    idle_inputs(); Rd_AddrA = 4'd1; Rd_AddrB = 4'd2;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h11 || dB[k] !== 8'h22) begin
        errors++;
        $display("FAIL src_alu_acc k=%0d got %h/%h exp 11/22", k, dA[k], dB[k]);
      end
    end
    @(negedge clk);
    Rd_AddrA = 4'd4; Rd_AddrB = 4'd5;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h33 || dB[k] !== 8'h00) begin
        errors++;
        $display("FAIL src_mem_rsv k=%0d got %h/%h exp 33/00", k, dA[k], dB[k]);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    Write_En = 1'b1; Src_Sel = 2'b10; Wr_Addr = 4'd7; ALU_Input = 8'h5C; Rd_AddrA = 4'd7;
    #1;
    checks++;
    if (dA[0] !== 8'h5C || dA[2] !== 8'h5C) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h/%h exp 5c/5c", dA[0], dA[2]);
    end
    checks++;
    if (dA[1] !== 8'h00) begin
      errors++;
      $display("FAIL nobypass_old got=%h exp=00", dA[1]);
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (dA[1] !== 8'h5C) begin
      errors++;
      $display("FAIL nobypass_next got=%h exp=5c", dA[1]);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    Load_Issue = 1'b1; Load_Addr = 4'd6;
    step();
    @(negedge clk);
    Load_Issue = 1'b0; Rd_AddrA = 4'd6; Rd_AddrB = 4'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (sA[k] !== 1'b1 || bz[k] !== 1'b1 || sB[k] !== 1'b0) begin
          errors++;
          $display("FAIL load_pending c=%0d k=%0d got stallA=%b busy=%b stallB=%b exp 1/1/0", c, k, sA[k], bz[k], sB[k]);
        end
      end
      Load_Issue = (c == 1); Load_Addr = 4'd9;
      step();
      @(negedge clk);
      Load_Issue = 1'b0;
    end
    Load_Done = 1'b1; Mem_Input = 8'h9E;
    #1;
    checks++;
    if (sA[0] !== 1'b0 || dA[0] !== 8'h9E || sA[1] !== 1'b1 || dA[1] !== 8'h00 || bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL load_done_cycle got stall=%b/%b data=%h/%h busy=%b exp 0/1 9e/00 1", sA[0], sA[1], dA[0], dA[1], bz[0]);
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bz[k] !== 1'b0 || sA[k] !== 1'b0 || dA[k] !== 8'h9E) begin
        errors++;
        $display("FAIL load_after k=%0d got busy=%b stall=%b data=%h exp 0/0/9e", k, bz[k], sA[k], dA[k]);
      end
    end
  endtask

  task automatic test_waw();
    @(negedge clk);
    Load_Issue = 1'b1; Load_Addr = 4'd2;
    step();
    @(negedge clk);
    Load_Issue = 1'b0; Write_En = 1'b1; Src_Sel = 2'b10; Wr_Addr = 4'd2; ALU_Input = 8'h44;
    Rd_AddrA = 4'd2;
    step();
    @(negedge clk);
    Write_En = 1'b0; Load_Done = 1'b1; Mem_Input = 8'hFF;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bz[k] !== 1'b0 || dA[k] !== 8'h44) begin
        errors++;
        $display("FAIL waw_cancel k=%0d got busy=%b data=%h exp 0/44", k, bz[k], dA[k]);
      end
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h44) begin
        errors++;
        $display("FAIL waw_final k=%0d got=%h exp=44", k, dA[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    Load_Issue = 1'b1; Load_Addr = 4'd8;
    step();
    @(negedge clk);
    Load_Issue = 1'b0; Write_En = 1'b1; Src_Sel = 2'b01; Wr_Addr = 4'd9; Acc_Input = 8'h3C;
    Load_Done = 1'b1; Mem_Input = 8'h81;
    step();
    @(negedge clk);
    idle_inputs(); Rd_AddrA = 4'd8; Rd_AddrB = 4'd9;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h81 || dB[k] !== 8'h3C || bz[k] !== 1'b0) begin
        errors++;
        $display("FAIL dual_commit k=%0d got %h/%h busy=%b exp 81/3c/0", k, dA[k], dB[k], bz[k]);
      end
    end
    Load_Issue = 1'b1; Load_Addr = 4'd10;
    step();
    @(negedge clk);
    Load_Issue = 1'b0; Write_En = 1'b1; Src_Sel = 2'b10; Wr_Addr = 4'd10; ALU_Input = 8'h66;
    Load_Done = 1'b1; Mem_Input = 8'h99; Rd_AddrA = 4'd10;
    #1;
    checks++;
    if (dA[0] !== 8'h66) begin
      errors++;
      $display("FAIL same_addr_bypass got=%h exp=66", dA[0]);
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dA[k] !== 8'h66 || bz[k] !== 1'b0) begin
        errors++;
        $display("FAIL same_addr_win k=%0d got %h busy=%b exp 66/0", k, dA[k], bz[k]);
      end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    Write_En = 1'b1; Src_Sel = 2'b10; Wr_Addr = 4'd0; ALU_Input = 8'h77;
    Load_Issue = 1'b1; Load_Addr = 4'd0; Rd_AddrA = 4'd0;
    #1;
    checks++;
    if (dA[2] !== 8'h00) begin
      errors++;
      $display("FAIL zero_bypass got=%h exp=00", dA[2]);
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (dA[2] !== 8'h00 || bz[2] !== 1'b0 || sA[2] !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg got data=%h busy=%b stall=%b exp 00/0/0", dA[2], bz[2], sA[2]);
    end
    checks++;
    if (dA[0] !== 8'h77 || bz[0] !== 1'b1 || sA[0] !== 1'b1) begin
      errors++;
      $display("FAIL r0_normal got data=%h busy=%b stall=%b exp 77/1/1", dA[0], bz[0], sA[0]);
    end
    Load_Done = 1'b1; Mem_Input = 8'h12;
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (dA[0] !== 8'h12 || dA[2] !== 8'h00 || bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL r0_load got %h/%h busy=%b exp 12/00/0", dA[0], dA[2], bz[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      Write_En   = ($urandom_range(0, 1) == 1);
      Src_Sel    = 2'($urandom_range(0, 3));
      Wr_Addr    = 4'($urandom_range(0, 15));
      ALU_Input  = 8'($urandom);
      Acc_Input  = 8'($urandom);
      Mem_Input  = 8'($urandom);
      Load_Issue = ($urandom_range(0, 3) == 0);
      Load_Addr  = 4'($urandom_range(0, 15));
      Load_Done  = ($urandom_range(0, 2) == 0);
      Rd_AddrA   = 4'($urandom_range(0, 15));
      Rd_AddrB   = (n % 3 == 0) ? mpa[0] : 4'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dA[k] !== m_read(k, Rd_AddrA) || dB[k] !== m_read(k, Rd_AddrB) ||
            sA[k] !== m_stall(k, Rd_AddrA) || sB[k] !== m_stall(k, Rd_AddrB) ||
            bz[k] !== mpend[k]) begin
          errors++;
          $display("FAIL random n=%0d k=%0d got A=%h B=%h sA=%b sB=%b busy=%b exp A=%h B=%h sA=%b sB=%b busy=%b",
                   n, k, dA[k], dB[k], sA[k], sB[k], bz[k],
                   m_read(k, Rd_AddrA), m_read(k, Rd_AddrB),
                   m_stall(k, Rd_AddrA), m_stall(k, Rd_AddrB), mpend[k]);
        end
      end
      step();
    end
  endtask

  initial begin
    Reset_n = 1'b1;
    idle_inputs();
    Src_Sel = 2'b00; Wr_Addr = 4'd0; ALU_Input = 8'h00; Acc_Input = 8'h00;
    Mem_Input = 8'h00; Load_Addr = 4'd0; Rd_AddrA = 4'd0; Rd_AddrB = 4'd0;
    m_clear();
    test_reset();
    test_src_mux();
    test_bypass();
    test_load();
    test_waw();
    test_back_to_back();
    test_zero_reg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_sb.md
# regfile_2r1w_sb

Parametrised register file with two combinational read ports, one encoded-source write port, optional write-to-read bypass, and a single-outstanding-load scoreboard. It sits between the decode stage and the ALU/accumulator/data-memory datapath. It replaces the single-port, one-hot-source register file. A load can be issued in one cycle and written back when memory responds, and reads of the pending destination raise a stall.

## Interface
Parameters:
- A, 4: address width; 2**A registers.
- W, 8: register width in bits.
- ZERO_REG, 0: if 1, register 0 reads as 0, ignores all writes, and never stalls.
- BYPASS, 1: if 1, reads see same-cycle committing write data.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Write_En  in  1  normal write strobe.
- Src_Sel  in  2  write source: 00 Mem_Input, 01 Acc_Input, 10 ALU_Input, 11 reserved (no write).
- Wr_Addr  in  A  normal write destination.
- ALU_Input / Acc_Input / Mem_Input  in  W each  write data sources; Mem_Input also carries load-return data.
- Load_Issue  in  1  start a load into Load_Addr.
- Load_Addr  in  A  load destination.
- Load_Done  in  1  memory data valid on Mem_Input for the pending load.
- Rd_AddrA, Rd_AddrB  in  A  read addresses.
- DataA, DataB  out  W  read data.
- Stall_A, Stall_B  out  1  read targets the pending load destination.
- Busy  out  1  a load is pending.

## Operation
- Storage: 2**A x W registers, plus state {IDLE, PENDING} and pend_addr[A-1:0].
- Normal write: at posedge, if Write_En and Src_Sel != 11, the selected source is written to Wr_Addr. Src_Sel=11 writes nothing.
- Load FSM:
  - IDLE + Load_Issue: pend_addr <= Load_Addr, state -> PENDING. Exception: with ZERO_REG=1 and Load_Addr=0, the state stays IDLE.
  - PENDING + Load_Done: Mem_Input is written to pend_addr, state -> IDLE.
  - PENDING + Load_Issue: ignored, no state change. The issuer must gate on Busy.
  - IDLE + Load_Done: ignored.
- WAW cancel: a normal write to pend_addr while PENDING commits, and the state goes to IDLE. The later Load_Done is then ignored, and program order is kept.
- Simultaneous normal write and Load_Done, different addresses: both commit in the same cycle.
- Simultaneous normal write and Load_Done, same address: the normal write wins, and the state goes to IDLE.
- Read (combinational), in priority order:
  1. ZERO_REG and address 0: returns 0.
  2. BYPASS and address matches this cycle's committing normal write: returns that source.
  3. BYPASS, Load_Done in PENDING, and address equals pend_addr: returns Mem_Input.
  4. Otherwise: returns the stored value.
- Stall_X = (state==PENDING) and (Rd_AddrX==pend_addr) and not (BYPASS and Load_Done). Stall_X is also forced to 0 for address 0 when ZERO_REG=1.
- Busy = (state==PENDING).

## Timing
- Reset_n low, asynchronous: all registers 0, state IDLE, pend_addr 0. Consequently DataA/B = 0, Stall_A/B = 0, Busy = 0.
- Reset_n asserted mid-load: the pending load is dropped. A Load_Done after reset release is ignored.
- Reads: zero latency. A written value appears on the stored path in the cycle after the write edge, or in the same cycle via bypass when BYPASS=1.
- Load_Issue to Busy high: 1 cycle, at the issue edge.
- Load_Done to Busy low: 1 cycle. With BYPASS=1, Stall drops combinationally in the Load_Done cycle. With BYPASS=0, it drops one cycle later.
- Load_Issue and Load_Done in the same PENDING cycle: the old load completes, and the new issue is ignored.
- Address widths are exact with no wrap logic. All 2**A entries are valid.

## Test plan
- Reset: write 0xA5 to r3, then pulse Reset_n low mid-cycle (asynchronous) -> DataA(r3)=0x00 immediately, Busy=0.
- Source mux: Src_Sel=10, ALU=0x11 to r1; 01, Acc=0x22 to r2; 00, Mem=0x33 to r4; 11 to r5 -> r1/r2/r4 = 0x11/0x22/0x33, r5 unchanged at 0.
- Bypass: BYPASS=1, write ALU=0x5C to r7 while Rd_AddrA=7 -> DataA=0x5C in the same cycle. With BYPASS=0, DataA shows the old value in that cycle and 0x5C the next cycle.
- Load scoreboard: issue a load to r6, read r6 -> Stall_A=1, Busy=1 for 3 cycles. Load_Done with Mem=0x9E -> Stall_A=0 in that cycle (BYPASS=1), DataA=0x9E, Busy=0 next cycle. A second Load_Issue while PENDING leaves pend_addr unchanged.
- WAW cancel: issue a load to r2, then normal write ALU=0x44 to r2, then Load_Done with Mem=0xFF -> r2=0x44, Busy=0 after the normal write.
- ZERO_REG=1: write 0x77 to r0 and issue a load to r0 -> DataA(r0)=0, Busy stays 0, Stall_A=0.
